// File: rtl/ct_hpcp_pkg.sv
// Shared defaults and helpers for the HPM event-counter bank.
// The optional overflow (OF) support is enabled by CT_HPCP_EVTCNT_SSCOFPMF_EN.
package ct_hpcp_pkg;

    localparam int HPMCNT_NUM_DEF   = 49;
    localparam int HPMEVT_WIDTH_DEF = 10;
    localparam int CNT_WIDTH_DEF    = 64;
    localparam int HPCP_DW          = 64;
    localparam int OF_BIT           = 63;

    // An event number is legal when it does not exceed the highest implemented event.
    function automatic logic evt_legal(input logic [31:0] evt, input logic [31:0] max_evt);
        return (evt <= max_evt);
    endfunction

endpackage

// File: rtl/ct_hpcp_evtcnt_chan.sv
// One HPM channel: event-select register, counter, optional OF flag, local ICG.
// OF flop exists only when CT_HPCP_EVTCNT_SSCOFPMF_EN is defined.
module ct_hpcp_evtcnt_chan
    import ct_hpcp_pkg::*;
#(
    parameter int HPMCNT_NUM   = HPMCNT_NUM_DEF,
    parameter int HPMEVT_WIDTH = HPMEVT_WIDTH_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    icg_en,
    input  logic                    scan_en,
    input  logic                    evt_wen,
    input  logic                    cnt_wen,
    input  logic [HPCP_DW-1:0]      wdata,
    input  logic                    inhibit,
    input  logic [HPMCNT_NUM:0]     event_vld,
    output logic [HPMEVT_WIDTH-1:0] sel,
    output logic [CNT_WIDTH-1:0]    cnt,
    output logic                    of
);

    logic [HPMEVT_WIDTH-1:0] sel_r;
    logic [HPMEVT_WIDTH-1:0] sel_nxt_s;
    logic [CNT_WIDTH-1:0]    cnt_r;
    logic [CNT_WIDTH-1:0]    cnt_nxt_s;
    logic                    evt_hit_s;
    logic                    inc_s;
    logic                    wrap_s;
    logic                    local_en_s;
    logic                    chan_clk_s;

    // Select the pulse of the chosen event; event 0 never counts.
    always_comb begin
        evt_hit_s = 1'b0;
        for (int e = 0; e <= HPMCNT_NUM; e++) begin
            evt_hit_s = evt_hit_s | (event_vld[e] & (sel_r == HPMEVT_WIDTH'(e)));
        end
    end

    assign inc_s      = (sel_r != {HPMEVT_WIDTH{1'b0}}) & ~inhibit & evt_hit_s;
    assign wrap_s     = inc_s & ~cnt_wen & (&cnt_r);
    assign local_en_s = inc_s | evt_wen | cnt_wen;

    // Next-state for select and counter; a counter write overrides the increment.
    always_comb begin
        sel_nxt_s = sel_r;
        cnt_nxt_s = cnt_r;
        if (evt_wen) begin
            if (evt_legal(32'(wdata[HPMEVT_WIDTH-1:0]), 32'(HPMCNT_NUM))) begin
                sel_nxt_s = wdata[HPMEVT_WIDTH-1:0];
            end else begin
                sel_nxt_s = {HPMEVT_WIDTH{1'b0}};
            end
        end else begin
            sel_nxt_s = sel_r;
        end
        if (cnt_wen) begin
            cnt_nxt_s = wdata[CNT_WIDTH-1:0];
        end else if (inc_s) begin
            cnt_nxt_s = cnt_r + CNT_WIDTH'(1'b1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    gated_clk_cell u_chan_icg (
        .clk_in             (forever_cpuclk),
        .global_en          (1'b1),
        .module_en          (icg_en),
        .local_en           (local_en_s),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (scan_en),
        .clk_out            (chan_clk_s)
    );

    // Select and counter state on the channel's gated clock.
    always_ff @(posedge chan_clk_s or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sel_r <= {HPMEVT_WIDTH{1'b0}};
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            sel_r <= sel_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

`ifdef CT_HPCP_EVTCNT_SSCOFPMF_EN
    logic of_r;
    logic of_nxt_s;

    // Hardware overflow wins over a software write to OF in the same cycle.
    always_comb begin
        of_nxt_s = of_r;
        if (wrap_s) begin
            of_nxt_s = 1'b1;
        end else if (evt_wen) begin
            of_nxt_s = wdata[OF_BIT];
        end else begin
            of_nxt_s = of_r;
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge chan_clk_s or negedge cpurst_b) begin
        if (!cpurst_b) begin
            of_r <= 1'b0;
        end else begin
            of_r <= of_nxt_s;
        end
    end

    assign of = of_r;
`else
    logic wrap_unused_s;
    assign wrap_unused_s = wrap_s;
    assign of            = 1'b0 & wrap_unused_s;
`endif

    assign sel = sel_r;
    assign cnt = cnt_r;

endmodule

// File: rtl/gated_clk_cell.sv
// Behavioural clock-gating cell: the enable is captured while the clock is low
// so the gated clock cannot glitch; scan enable forces the clock on.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en_s;
    logic clk_en_r;

    assign clk_en_s = (global_en & (module_en | local_en)) | external_en | pad_yy_icg_scan_en;

    // Enable capture on the low phase of the clock.
    always_ff @(negedge clk_in) begin
        clk_en_r <= clk_en_s;
    end

    assign clk_out = clk_in & clk_en_r;

endmodule

// File: rtl/ct_hpcp_evtcnt_bank.sv
// Bank of CNT_NUM HPM event counters: write decode, read mux and overflow interrupt.
// Overflow reporting is enabled by CT_HPCP_EVTCNT_SSCOFPMF_EN.
module ct_hpcp_evtcnt_bank
    import ct_hpcp_pkg::*;
#(
    parameter int CNT_NUM      = 4,
    parameter int IDX_W        = 2,
    parameter int HPMCNT_NUM   = HPMCNT_NUM_DEF,
    parameter int HPMEVT_WIDTH = HPMEVT_WIDTH_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst_b,
    input  logic                 cp0_hpcp_icg_en,
    input  logic                 pad_yy_icg_scan_en,
    input  logic                 hpcp_evt_wen,
    input  logic                 hpcp_cnt_wen,
    input  logic [IDX_W-1:0]     hpcp_widx,
    input  logic [HPCP_DW-1:0]   hpcp_wdata,
    input  logic [CNT_NUM-1:0]   hpcp_inhibit,
    input  logic [HPMCNT_NUM:0]  hpcp_event_vld,
    input  logic [IDX_W-1:0]     hpcp_ridx,
    output logic [HPCP_DW-1:0]   hpcp_evt_rdata,
    output logic [HPCP_DW-1:0]   hpcp_cnt_rdata,
    output logic [CNT_NUM-1:0]   hpcp_of_vec,
    output logic                 hpcp_ovf_int
);

    logic [CNT_NUM-1:0]      evt_wen_s;
    logic [CNT_NUM-1:0]      cnt_wen_s;
    logic [CNT_NUM-1:0]      of_s;
    logic [HPMEVT_WIDTH-1:0] sel_s [CNT_NUM];
    logic [CNT_WIDTH-1:0]    cnt_s [CNT_NUM];
    logic [HPCP_DW-1:0]      evt_rdata_s;
    logic [HPCP_DW-1:0]      cnt_rdata_s;

    // Write decode; an index with no matching channel selects nothing.
    always_comb begin
        evt_wen_s = {CNT_NUM{1'b0}};
        cnt_wen_s = {CNT_NUM{1'b0}};
        for (int i = 0; i < CNT_NUM; i++) begin
            evt_wen_s[i] = hpcp_evt_wen & (hpcp_widx == IDX_W'(i));
            cnt_wen_s[i] = hpcp_cnt_wen & (hpcp_widx == IDX_W'(i));
        end
    end

    for (genvar g = 0; g < CNT_NUM; g++) begin : g_chan
        ct_hpcp_evtcnt_chan #(
            .HPMCNT_NUM   (HPMCNT_NUM),
            .HPMEVT_WIDTH (HPMEVT_WIDTH),
            .CNT_WIDTH    (CNT_WIDTH)
        ) u_chan (
            .forever_cpuclk (forever_cpuclk),
            .cpurst_b       (cpurst_b),
            .icg_en         (cp0_hpcp_icg_en),
            .scan_en        (pad_yy_icg_scan_en),
            .evt_wen        (evt_wen_s[g]),
            .cnt_wen        (cnt_wen_s[g]),
            .wdata          (hpcp_wdata),
            .inhibit        (hpcp_inhibit[g]),
            .event_vld      (hpcp_event_vld),
            .sel            (sel_s[g]),
            .cnt            (cnt_s[g]),
            .of             (of_s[g])
        );
    end

    // Combinational read mux; an unmatched index reads back zero.
    always_comb begin
        evt_rdata_s = {HPCP_DW{1'b0}};
        cnt_rdata_s = {HPCP_DW{1'b0}};
        for (int i = 0; i < CNT_NUM; i++) begin
`ifdef CT_HPCP_EVTCNT_SSCOFPMF_EN
            evt_rdata_s = evt_rdata_s | ((hpcp_ridx == IDX_W'(i)) ?
                          ({of_s[i], {(HPCP_DW-1){1'b0}}} | HPCP_DW'(sel_s[i])) : {HPCP_DW{1'b0}});
`else
            evt_rdata_s = evt_rdata_s | ((hpcp_ridx == IDX_W'(i)) ?
                          HPCP_DW'(sel_s[i]) : {HPCP_DW{1'b0}});
`endif
            cnt_rdata_s = cnt_rdata_s | ((hpcp_ridx == IDX_W'(i)) ?
                          HPCP_DW'(cnt_s[i]) : {HPCP_DW{1'b0}});
        end
    end

    assign hpcp_evt_rdata = evt_rdata_s;
    assign hpcp_cnt_rdata = cnt_rdata_s;
    assign hpcp_of_vec    = of_s;

`ifdef CT_HPCP_EVTCNT_SSCOFPMF_EN
    logic ovf_int_r;

    // Interrupt request follows the OR of all OF flags one cycle later.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ovf_int_r <= 1'b0;
        end else begin
            ovf_int_r <= |of_s;
        end
    end

    assign hpcp_ovf_int = ovf_int_r;
`else
    assign hpcp_ovf_int = 1'b0;
`endif

endmodule

// File: tb/tb_ct_hpcp_evtcnt_bank.sv
// Directed self-checking bench for ct_hpcp_evtcnt_bank (default build or with
// CT_HPCP_EVTCNT_SSCOFPMF_EN defined).
module tb_ct_hpcp_evtcnt_bank;

`ifdef CT_HPCP_EVTCNT_SSCOFPMF_EN
    localparam bit SSC = 1'b1;
`else
    localparam bit SSC = 1'b0;
`endif

    logic        forever_cpuclk;
    logic        cpurst_b;
    logic        cp0_hpcp_icg_en;
    logic        pad_yy_icg_scan_en;
    logic        hpcp_evt_wen;
    logic        hpcp_cnt_wen;
    logic [1:0]  hpcp_widx;
    logic [63:0] hpcp_wdata;
    logic [3:0]  hpcp_inhibit;
    logic [49:0] hpcp_event_vld;
    logic [1:0]  hpcp_ridx;
    logic [63:0] hpcp_evt_rdata;
    logic [63:0] hpcp_cnt_rdata;
    logic [3:0]  hpcp_of_vec;
    logic        hpcp_ovf_int;

    int n_checks = 0;
    int n_pass   = 0;

    ct_hpcp_evtcnt_bank dut (
        .forever_cpuclk     (forever_cpuclk),
        .cpurst_b           (cpurst_b),
        .cp0_hpcp_icg_en    (cp0_hpcp_icg_en),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .hpcp_evt_wen       (hpcp_evt_wen),
        .hpcp_cnt_wen       (hpcp_cnt_wen),
        .hpcp_widx          (hpcp_widx),
        .hpcp_wdata         (hpcp_wdata),
        .hpcp_inhibit       (hpcp_inhibit),
        .hpcp_event_vld     (hpcp_event_vld),
        .hpcp_ridx          (hpcp_ridx),
        .hpcp_evt_rdata     (hpcp_evt_rdata),
        .hpcp_cnt_rdata     (hpcp_cnt_rdata),
        .hpcp_of_vec        (hpcp_of_vec),
        .hpcp_ovf_int       (hpcp_ovf_int)
    );

    initial begin
        forever_cpuclk = 1'b0;
        forever #5 forever_cpuclk = ~forever_cpuclk;
    end

    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic clear_inputs();
        hpcp_evt_wen   = 1'b0;
        hpcp_cnt_wen   = 1'b0;
        hpcp_widx      = 2'd0;
        hpcp_wdata     = 64'd0;
        hpcp_inhibit   = 4'd0;
        hpcp_event_vld = 50'd0;
    endtask

    task automatic test_reset();
        cpurst_b = 1'b0;
        clear_inputs();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            hpcp_ridx = 2'(i);
            #1;
            n_checks++;
            if (hpcp_evt_rdata !== 64'd0 || hpcp_cnt_rdata !== 64'd0)
                $display("FAIL reset_rdata ch%0d: evt=%h cnt=%h required 0", i, hpcp_evt_rdata, hpcp_cnt_rdata);
            else n_pass++;
        end
        n_checks++;
        if (hpcp_of_vec !== 4'd0 || hpcp_ovf_int !== 1'b0)
            $display("FAIL reset_of: of_vec=%b ovf=%b required 0/0", hpcp_of_vec, hpcp_ovf_int);
        else n_pass++;
        cpurst_b = 1'b1;
        tick();
    endtask

    task automatic test_evt_sel();
        logic [63:0] wv [4];
        logic [63:0] ev [4];
        wv[0] = 64'd49;  ev[0] = 64'd49;
        wv[1] = 64'd50;  ev[1] = 64'd0;
        wv[2] = 64'h3FF; ev[2] = 64'd0;
        wv[3] = 64'd1;   ev[3] = 64'd1;
        hpcp_ridx = 2'd1;
        for (int k = 0; k < 4; k++) begin
            hpcp_widx    = 2'd1;
            hpcp_wdata   = wv[k];
            hpcp_evt_wen = 1'b1;
            tick();
            hpcp_evt_wen = 1'b0;
            #1;
            n_checks++;
            if (hpcp_evt_rdata !== ev[k])
                $display("FAIL evt_sel wdata=%h: got %h required %h", wv[k], hpcp_evt_rdata, ev[k]);
            else n_pass++;
        end
        hpcp_widx = 2'd1; hpcp_wdata = 64'd0; hpcp_evt_wen = 1'b1;
        tick();
        hpcp_evt_wen = 1'b0;
    endtask

    task automatic test_inhibit();
        hpcp_widx = 2'd2; hpcp_wdata = 64'd5; hpcp_evt_wen = 1'b1;
        tick();
        hpcp_evt_wen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            hpcp_event_vld    = 50'd0;
            hpcp_event_vld[5] = 1'b1;
            hpcp_event_vld[0] = 1'b1;
            hpcp_inhibit[2]   = (c >= 3 && c < 6);
            tick();
        end
        clear_inputs();
        hpcp_ridx = 2'd2;
        #1;
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd7)
            $display("FAIL inhibit_cnt: got %0d required 7", hpcp_cnt_rdata);
        else n_pass++;
        hpcp_ridx = 2'd1;
        #1;
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd0)
            $display("FAIL sel0_no_count: got %0d required 0", hpcp_cnt_rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back_wen();
        hpcp_widx = 2'd2; hpcp_wdata = 64'd5;
        hpcp_evt_wen = 1'b1; hpcp_cnt_wen = 1'b1;
        hpcp_event_vld[5] = 1'b1;
        tick();
        clear_inputs();
        hpcp_ridx = 2'd2;
        #1;
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd5 || hpcp_evt_rdata !== 64'd5)
            $display("FAIL dual_wen: cnt=%0d evt=%0d required 5/5", hpcp_cnt_rdata, hpcp_evt_rdata);
        else n_pass++;
    endtask

    task automatic test_wrap();
        hpcp_widx = 2'd0; hpcp_wdata = 64'd3; hpcp_evt_wen = 1'b1;
        tick();
        hpcp_evt_wen = 1'b0;
        hpcp_ridx = 2'd0;
        hpcp_wdata = 64'hFFFF_FFFF_FFFF_FFFE; hpcp_cnt_wen = 1'b1;
        hpcp_event_vld[3] = 1'b1;
        tick();
        hpcp_cnt_wen = 1'b0;
        n_checks++;
        if (hpcp_cnt_rdata !== 64'hFFFF_FFFF_FFFF_FFFE)
            $display("FAIL wrap_load: got %h required fffffffffffffffe", hpcp_cnt_rdata);
        else n_pass++;
        tick();
        n_checks++;
        if (hpcp_cnt_rdata !== 64'hFFFF_FFFF_FFFF_FFFF || hpcp_of_vec !== 4'd0)
            $display("FAIL wrap_ones: cnt=%h of=%b required ffffffffffffffff/0000", hpcp_cnt_rdata, hpcp_of_vec);
        else n_pass++;
        tick();
        hpcp_event_vld = 50'd0;
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd0 || hpcp_of_vec !== {3'b000, SSC} || hpcp_ovf_int !== 1'b0)
            $display("FAIL wrap_zero: cnt=%h of=%b ovf=%b required 0/%b/0", hpcp_cnt_rdata, hpcp_of_vec, hpcp_ovf_int, {3'b000, SSC});
        else n_pass++;
        tick();
        n_checks++;
        if (hpcp_ovf_int !== SSC || hpcp_evt_rdata !== (SSC ? 64'h8000_0000_0000_0003 : 64'd3))
            $display("FAIL wrap_int: ovf=%b evt=%h required %b", hpcp_ovf_int, hpcp_evt_rdata, SSC);
        else n_pass++;
        hpcp_ridx = 2'd2;
        #1;
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd5)
            $display("FAIL wrap_other_ch: got %0d required 5", hpcp_cnt_rdata);
        else n_pass++;
    endtask

    task automatic test_priority();
        hpcp_widx = 2'd3; hpcp_wdata = 64'd7; hpcp_evt_wen = 1'b1;
        tick();
        hpcp_evt_wen = 1'b0;
        hpcp_ridx = 2'd3;
        hpcp_event_vld[7] = 1'b1;
        tick();
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd1)
            $display("FAIL prio_inc: got %0d required 1", hpcp_cnt_rdata);
        else n_pass++;
        hpcp_wdata = 64'd100; hpcp_cnt_wen = 1'b1;
        tick();
        hpcp_cnt_wen = 1'b0;
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd100)
            $display("FAIL prio_write: got %0d required 100", hpcp_cnt_rdata);
        else n_pass++;
        tick();
        hpcp_event_vld = 50'd0;
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd101)
            $display("FAIL prio_after: got %0d required 101", hpcp_cnt_rdata);
        else n_pass++;
    endtask

    task automatic test_of_clear();
        hpcp_ridx = 2'd0;
        hpcp_widx = 2'd0; hpcp_wdata = 64'hFFFF_FFFF_FFFF_FFFF; hpcp_cnt_wen = 1'b1;
        tick();
        hpcp_cnt_wen = 1'b0;
        hpcp_wdata = 64'd3; hpcp_evt_wen = 1'b1;
        hpcp_event_vld[3] = 1'b1;
        tick();
        clear_inputs();
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd0 || hpcp_of_vec[0] !== SSC || hpcp_evt_rdata !== (SSC ? 64'h8000_0000_0000_0003 : 64'd3))
            $display("FAIL of_hw_wins: cnt=%h of=%b evt=%h required 0/%b", hpcp_cnt_rdata, hpcp_of_vec[0], hpcp_evt_rdata, SSC);
        else n_pass++;
        hpcp_widx = 2'd0; hpcp_wdata = 64'd3; hpcp_evt_wen = 1'b1;
        tick();
        hpcp_evt_wen = 1'b0;
        n_checks++;
        if (hpcp_of_vec !== 4'd0 || hpcp_ovf_int !== SSC)
            $display("FAIL of_sw_clear: of=%b ovf=%b required 0000/%b", hpcp_of_vec, hpcp_ovf_int, SSC);
        else n_pass++;
        tick();
        n_checks++;
        if (hpcp_ovf_int !== 1'b0 || hpcp_evt_rdata !== 64'd3)
            $display("FAIL of_int_drop: ovf=%b evt=%h required 0/3", hpcp_ovf_int, hpcp_evt_rdata);
        else n_pass++;
    endtask

    task automatic test_icg();
        cp0_hpcp_icg_en = 1'b0; pad_yy_icg_scan_en = 1'b1;
        hpcp_ridx = 2'd2;
        hpcp_event_vld[5] = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd9)
            $display("FAIL icg_scan: got %0d required 9", hpcp_cnt_rdata);
        else n_pass++;
        pad_yy_icg_scan_en = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd12)
            $display("FAIL icg_local: got %0d required 12", hpcp_cnt_rdata);
        else n_pass++;
        hpcp_inhibit[2] = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd12)
            $display("FAIL icg_inhibit: got %0d required 12", hpcp_cnt_rdata);
        else n_pass++;
        clear_inputs();
        cp0_hpcp_icg_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        hpcp_ridx = 2'd2;
        @(posedge forever_cpuclk);
        #2;
        cpurst_b = 1'b0;
        #1;
        n_checks++;
        if (hpcp_cnt_rdata !== 64'd0 || hpcp_evt_rdata !== 64'd0 || hpcp_of_vec !== 4'd0 || hpcp_ovf_int !== 1'b0)
            $display("FAIL reset_mid: cnt=%h evt=%h of=%b ovf=%b required all 0", hpcp_cnt_rdata, hpcp_evt_rdata, hpcp_of_vec, hpcp_ovf_int);
        else n_pass++;
        tick();
        cpurst_b = 1'b1;
        tick();
    endtask

    initial begin
        cp0_hpcp_icg_en    = 1'b1;
        pad_yy_icg_scan_en = 1'b0;
        hpcp_ridx          = 2'd0;
        test_reset();
        test_evt_sel();
        test_inhibit();
        test_back_to_back_wen();
        test_wrap();
        test_priority();
        test_of_clear();
        test_icg();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
